// File: rtl/dest_reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : dest_reg_scoreboard_if
//  Description : Decode/write-back bundle between the pipeline and the
//                destination-register scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dest_reg_scoreboard_if;
    logic        flush;
    logic        issue_valid;
    logic        issue_wr;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs;
    logic        issue_rs_use;
    logic [4:0]  issue_rt;
    logic        issue_rt_use;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        stall;
    logic [31:0] busy_mask;
    logic        sb_error;

    modport master (
        output flush, issue_valid, issue_wr, issue_rd, issue_rs, issue_rs_use,
               issue_rt, issue_rt_use, wb_valid, wb_rd,
        input  stall, busy_mask, sb_error
    );

    modport slave (
        input  flush, issue_valid, issue_wr, issue_rd, issue_rs, issue_rs_use,
               issue_rt, issue_rt_use, wb_valid, wb_rd,
        output stall, busy_mask, sb_error
    );
endinterface
`default_nettype wire

// File: rtl/dest_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : dest_reg_scoreboard
//  Description : Per-register in-flight write counters; stalls decode on
//                RAW / destination-saturation hazards. Optional same-cycle
//                write-back release via SCOREBOARD_WB_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dest_reg_scoreboard #(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    dest_reg_scoreboard_if.slave  sb
);

    localparam int               c_nregs = 32;
    localparam logic [CNT_W-1:0] c_max   = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero  = '0;

    logic [c_nregs-1:0][CNT_W-1:0] r_count;
    logic [c_nregs-1:0][CNT_W-1:0] w_count_nxt;
    logic [c_nregs-1:0]            r_busy_mask;
    logic [c_nregs-1:0]            w_busy_nxt;
    logic                          r_sb_error;

    logic [CNT_W-1:0] w_rs_cnt;
    logic [CNT_W-1:0] w_rt_cnt;
    logic [CNT_W-1:0] w_rd_cnt;
    logic [CNT_W-1:0] w_wb_cnt;
    logic             w_rs_nz;
    logic             w_rt_nz;
    logic             w_rd_nz;
    logic             w_wb_nz;
    logic             w_rs_byp;
    logic             w_rt_byp;
    logic             w_rd_byp;
    logic             w_rs_haz;
    logic             w_rt_haz;
    logic             w_rd_haz;
    logic             w_stall;
    logic             w_accept;
    logic             w_retire;
    logic             w_underflow;

    assign w_rs_cnt = r_count[sb.issue_rs];
    assign w_rt_cnt = r_count[sb.issue_rt];
    assign w_rd_cnt = r_count[sb.issue_rd];
    assign w_wb_cnt = r_count[sb.wb_rd];

    assign w_rs_nz = (sb.issue_rs != 5'd0);
    assign w_rt_nz = (sb.issue_rt != 5'd0);
    assign w_rd_nz = (sb.issue_rd != 5'd0);
    assign w_wb_nz = (sb.wb_rd    != 5'd0);

`ifdef SCOREBOARD_WB_BYPASS_EN
    // Last outstanding write retiring now: register file forwards it this cycle.
    assign w_rs_byp = sb.wb_valid && (sb.wb_rd == sb.issue_rs) && (w_rs_cnt == c_one);
    assign w_rt_byp = sb.wb_valid && (sb.wb_rd == sb.issue_rt) && (w_rt_cnt == c_one);
    assign w_rd_byp = sb.wb_valid && (sb.wb_rd == sb.issue_rd);
`else
    assign w_rs_byp = 1'b0;
    assign w_rt_byp = 1'b0;
    assign w_rd_byp = 1'b0;
`endif

    assign w_rs_haz = sb.issue_rs_use && w_rs_nz && (w_rs_cnt != c_zero) && !w_rs_byp;
    assign w_rt_haz = sb.issue_rt_use && w_rt_nz && (w_rt_cnt != c_zero) && !w_rt_byp;
    assign w_rd_haz = sb.issue_wr && w_rd_nz && (w_rd_cnt == c_max) && !w_rd_byp;

    assign w_stall     = sb.issue_valid && (w_rs_haz || w_rt_haz || w_rd_haz);
    assign w_accept    = sb.issue_valid && !w_stall && sb.issue_wr && w_rd_nz;
    assign w_retire    = sb.wb_valid && w_wb_nz;
    assign w_underflow = w_retire && (w_wb_cnt == c_zero);

    for (genvar gi = 0; gi < c_nregs; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign w_count_nxt[gi] = c_zero;
        end else begin : g_live
            logic w_inc;
            logic w_dec;
            assign w_inc = w_accept && (sb.issue_rd == 5'(gi));
            assign w_dec = w_retire && (sb.wb_rd == 5'(gi));
            // Coincident accept and retire cancel; an empty counter never wraps.
            assign w_count_nxt[gi] =
                (w_inc && !w_dec)                           ? r_count[gi] + c_one :
                (w_dec && !w_inc && r_count[gi] != c_zero)  ? r_count[gi] - c_one :
                                                              r_count[gi];
        end
        assign w_busy_nxt[gi] = (w_count_nxt[gi] != c_zero);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_busy_mask <= '0;
            r_sb_error  <= 1'b0;
        end else if (sb.flush) begin
            r_count     <= '0;
            r_busy_mask <= '0;
        end else begin
            r_count     <= w_count_nxt;
            r_busy_mask <= w_busy_nxt;
            if (w_underflow) begin
                r_sb_error <= 1'b1;
            end
        end
    end

    assign sb.stall     = w_stall;
    assign sb.busy_mask = r_busy_mask;
    assign sb.sb_error  = r_sb_error;

endmodule
`default_nettype wire

// File: tb/tb_dest_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dest_reg_scoreboard
//  Description : Directed + random bench with a counter-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dest_reg_scoreboard;

    localparam int MAXP = 4;
    localparam int CW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dest_reg_scoreboard_if sb_if ();

    dest_reg_scoreboard #(.MAX_PENDING(MAXP), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if.slave)
    );

    int   n_vec  = 0;
    int   n_fail = 0;
    int   cnt [32];
    bit   m_err  = 1'b0;
    bit   exp_stall = 1'b0;
    bit   chk_en = 1'b0;
    logic last_stall = 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m = '0;
        for (int i = 0; i < 32; i++) m[i] = (cnt[i] != 0);
        return m;
    endfunction

    function automatic bit src_hazard(input logic use_f, input logic [4:0] idx);
        bit bypass = BYP && sb_if.wb_valid && (sb_if.wb_rd == idx) && (cnt[idx] == 1);
        return use_f && (idx != 0) && (cnt[idx] != 0) && !bypass;
    endfunction

    function automatic bit model_stall();
        bit dst_bypass = BYP && sb_if.wb_valid && (sb_if.wb_rd == sb_if.issue_rd);
        bit dst = sb_if.issue_wr && (sb_if.issue_rd != 0) && (cnt[sb_if.issue_rd] == MAXP) && !dst_bypass;
        return sb_if.issue_valid &&
               (src_hazard(sb_if.issue_rs_use, sb_if.issue_rs) ||
                src_hazard(sb_if.issue_rt_use, sb_if.issue_rt) || dst);
    endfunction

    task automatic model_step();
        bit acc, ret;
        logic [4:0] rd, wr;
        rd = sb_if.issue_rd;
        wr = sb_if.wb_rd;
        if (rst) begin
            foreach (cnt[i]) cnt[i] = 0;
            m_err = 1'b0;
        end else if (sb_if.flush) begin
            foreach (cnt[i]) cnt[i] = 0;
        end else begin
            acc = !model_stall() && sb_if.issue_valid && sb_if.issue_wr && (rd != 0);
            ret = sb_if.wb_valid && (wr != 0);
            if (ret && cnt[wr] == 0) m_err = 1'b1;
            if (!(acc && ret && rd == wr)) begin
                if (acc) cnt[rd]++;
                if (ret && cnt[wr] > 0) cnt[wr]--;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            last_stall = sb_if.stall;
            chk("stall", {31'd0, sb_if.stall}, {31'd0, exp_stall});
            chk("busy_mask", sb_if.busy_mask, model_busy());
            chk("sb_error", {31'd0, sb_if.sb_error}, {31'd0, m_err});
        end
    end

    task automatic idle();
        sb_if.flush = 0; sb_if.issue_valid = 0; sb_if.issue_wr = 0;
        sb_if.issue_rd = 0; sb_if.issue_rs = 0; sb_if.issue_rs_use = 0;
        sb_if.issue_rt = 0; sb_if.issue_rt_use = 0;
        sb_if.wb_valid = 0; sb_if.wb_rd = 0;
    endtask

    task automatic cycle();
        exp_stall = model_stall();
        @(negedge clk);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic issue_w(input logic [4:0] rd);
        idle(); sb_if.issue_valid = 1; sb_if.issue_wr = 1; sb_if.issue_rd = rd;
    endtask

    initial begin
        foreach (cnt[i]) cnt[i] = 0;
        idle();
        rst = 1;
        cycle(); cycle();
        rst = 0;
        chk_en = 1;
        chk("reset busy_mask", sb_if.busy_mask, 32'd0);
        chk("reset sb_error", {31'd0, sb_if.sb_error}, 32'd0);

        // idle read of r5 with nothing pending
        idle(); sb_if.issue_valid = 1; sb_if.issue_rs = 5; sb_if.issue_rs_use = 1;
        cycle();
        chk("idle read stall", {31'd0, last_stall}, 32'd0);

        // RAW on r5
        issue_w(5); cycle();
        chk("raw busy5", {31'd0, sb_if.busy_mask[5]}, 32'd1);
        idle(); sb_if.issue_valid = 1; sb_if.issue_rs = 5; sb_if.issue_rs_use = 1;
        cycle();
        chk("raw stall", {31'd0, last_stall}, 32'd1);
        sb_if.wb_valid = 1; sb_if.wb_rd = 5;
        cycle();
        chk("raw retire-cycle stall", {31'd0, last_stall}, {31'd0, !BYP});
        sb_if.wb_valid = 0;
        cycle();
        chk("raw released", {31'd0, last_stall}, 32'd0);
        chk("raw busy5 clear", {31'd0, sb_if.busy_mask[5]}, 32'd0);

        // saturation on r7
        for (int k = 0; k < 4; k++) begin issue_w(7); cycle(); end
        chk("sat busy7", {31'd0, sb_if.busy_mask[7]}, 32'd1);
        issue_w(7); cycle();
        chk("sat 5th stall", {31'd0, last_stall}, 32'd1);
        sb_if.wb_valid = 1; sb_if.wb_rd = 7;
        cycle();
        chk("sat retire-cycle stall", {31'd0, last_stall}, {31'd0, !BYP});
        if (!BYP) begin
            sb_if.wb_valid = 0;
            cycle();
            chk("sat 5th accepted", {31'd0, last_stall}, 32'd0);
        end
        idle();
        for (int k = 0; k < 4; k++) begin sb_if.wb_valid = 1; sb_if.wb_rd = 7; cycle(); end
        chk("sat drained", {31'd0, sb_if.busy_mask[7]}, 32'd0);
        chk("sat no error", {31'd0, sb_if.sb_error}, 32'd0);

        // simultaneous accept/retire on r9
        issue_w(9); cycle();
        issue_w(9); sb_if.wb_valid = 1; sb_if.wb_rd = 9; cycle();
        chk("simul busy9", {31'd0, sb_if.busy_mask[9]}, 32'd1);
        idle(); sb_if.wb_valid = 1; sb_if.wb_rd = 9; cycle();
        chk("simul busy9 after one retire", {31'd0, sb_if.busy_mask[9]}, 32'd0);
        chk("simul no error", {31'd0, sb_if.sb_error}, 32'd0);

        // r0 is never tracked
        idle(); sb_if.issue_valid = 1; sb_if.issue_wr = 1; sb_if.issue_rs_use = 1;
        sb_if.issue_rt_use = 1; sb_if.wb_valid = 1;
        cycle(); cycle();
        chk("r0 stall", {31'd0, last_stall}, 32'd0);
        chk("r0 busy", {31'd0, sb_if.busy_mask[0]}, 32'd0);
        chk("r0 error", {31'd0, sb_if.sb_error}, 32'd0);

        // underflow on r12, sticky through flush
        idle(); sb_if.wb_valid = 1; sb_if.wb_rd = 12; cycle();
        chk("underflow error", {31'd0, sb_if.sb_error}, 32'd1);
        idle(); sb_if.flush = 1; cycle();
        chk("error survives flush", {31'd0, sb_if.sb_error}, 32'd1);

        // flush discards pending and same-cycle issue
        issue_w(3); cycle();
        issue_w(4); cycle();
        chk("pre-flush busy", sb_if.busy_mask, 32'h0000_0018);
        issue_w(6); sb_if.flush = 1; cycle();
        chk("flush busy", sb_if.busy_mask, 32'd0);
        idle(); cycle();
        chk("flush r6 discarded", sb_if.busy_mask, 32'd0);

        idle(); rst = 1; cycle(); rst = 0;
        chk("rst clears error", {31'd0, sb_if.sb_error}, 32'd0);

        // randomized traffic on a small register window to force collisions
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst                = ($urandom_range(0, 299) == 0);
            sb_if.flush        = ($urandom_range(0, 59) == 0);
            sb_if.issue_valid  = ($urandom_range(0, 3) != 0);
            sb_if.issue_wr     = ($urandom_range(0, 3) != 0);
            sb_if.issue_rd     = 5'($urandom_range(0, 7));
            sb_if.issue_rs     = 5'($urandom_range(0, 7));
            sb_if.issue_rs_use = 1'($urandom_range(0, 1));
            sb_if.issue_rt     = 5'($urandom_range(0, 7));
            sb_if.issue_rt_use = 1'($urandom_range(0, 1));
            sb_if.wb_valid     = ($urandom_range(0, 2) == 0);
            sb_if.wb_rd        = 5'($urandom_range(0, 7));
            cycle();
        end
        rst = 0;
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
